// File: rtl/hs_ram_arbiter.sv
// rtl/hs_ram_arbiter.sv - shares the game work RAM port between the CPU and the hiscore engine,
// halting the CPU through the pause chain before the hiscore side takes the port.
module hs_ram_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int SETTLE = 2,
  parameter int HOLD   = 4,
  parameter int TO_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_dout,
  input  logic [ADDR_W-1:0] hs_address,
  input  logic [DATA_W-1:0] hs_data_in,
  input  logic              hs_write_enable,
  input  logic              hs_read_intent,
  input  logic              hs_write_intent,
  output logic [DATA_W-1:0] hs_data_out,
  input  logic              paused,
  output logic              pause_req,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  output logic              ram_we,
  input  logic [DATA_W-1:0] ram_dout,
  output logic              hs_granted,
  output logic              timeout_err
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ     = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_GRANT   = 3'd3;
  localparam logic [2:0] S_RELEASE = 3'd4;

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE - 1);
  localparam logic [3:0]      HOLD_LD   = 4'(HOLD);
  localparam logic [TO_W-1:0] TO_MAX    = '1;
  localparam logic [TO_W-1:0] TO_ONE    = TO_W'(1);
  localparam logic [TO_W-1:0] TO_LAST   = TO_MAX - TO_ONE;

  logic [2:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [TO_W-1:0]   to_q, to_d;
  logic              terr_q, terr_d;
  logic              gnt_dly_q;
  logic [DATA_W-1:0] hs_dout_q;

  logic intent;
  logic grant_live;

  assign intent     = hs_read_intent | hs_write_intent;
  // Losing the pause acknowledge revokes the grant in the same cycle.
  assign grant_live = (state_q == S_GRANT) && paused;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    to_d    = to_q;
    terr_d  = terr_q;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        to_d  = '0;
        if (intent) state_d = S_REQ;
      end
      S_REQ: begin
        if (!intent) begin
          state_d = S_IDLE;
        end else if (paused) begin
          state_d = S_SETTLE;
          cnt_d   = SETTLE_LD;
        end else begin
          if (to_q != TO_MAX) to_d = to_q + TO_ONE;
          if (to_q >= TO_LAST) begin
            state_d = S_IDLE;
            terr_d  = 1'b1;
          end
        end
      end
      S_SETTLE: begin
        if (!paused) begin
          state_d = S_REQ;
        end else if (cnt_q == 4'd0) begin
          state_d = S_GRANT;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_GRANT: begin
        to_d = '0;
        if (!paused) begin
          state_d = S_REQ;
        end else if (intent) begin
          cnt_d = HOLD_LD;
        end else if (cnt_q == 4'd0) begin
          state_d = S_RELEASE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RELEASE: begin
        to_d    = '0;
        state_d = intent ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      to_q      <= '0;
      terr_q    <= 1'b0;
      gnt_dly_q <= 1'b0;
      hs_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      to_q      <= to_d;
      terr_q    <= terr_d;
      gnt_dly_q <= grant_live;
      if (gnt_dly_q) hs_dout_q <= ram_dout;
    end
  end

  // The CPU stays halted from REQ through RELEASE, so it never runs while the hiscore side owns the port.
  assign pause_req   = (state_q == S_REQ) || (state_q == S_SETTLE) ||
                       (state_q == S_GRANT) || (state_q == S_RELEASE);
  assign hs_granted  = grant_live;
  assign ram_addr    = grant_live ? hs_address : cpu_addr;
  assign ram_din     = grant_live ? hs_data_in : cpu_din;
  assign ram_we      = grant_live ? hs_write_enable : ((state_q != S_GRANT) && cpu_we);
  assign cpu_dout    = ram_dout;
  assign hs_data_out = hs_dout_q;
  assign timeout_err = terr_q;

endmodule
